rf_dbg_master: RTL and testbench
================================

# rf_dbg_master

Debug access initiator for the register file. It accepts debug read, write and dump commands on a valid/ready command channel and requests a core halt. Once the core is halted, it takes ownership of the RF read and write ports and returns results on a valid/ready response channel. It sits between the debug transport and the RF port mux (`o_rf_sel`) in front of `rf`, and relies on the RF's asynchronous read and synchronous write behaviour.

## Interface
- HALT_TIMEOUT, 16: consecutive WAIT_HALT cycles with `i_halted` low before the command is aborted with an error (≥1).

- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command accepted when valid & ready
- i_cmd_op  in  2  00 read, 01 write, 10 dump all, 11 illegal
- i_cmd_addr  in  5  register index (ignored for dump)
- i_cmd_wdata  in  32  write data
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumed when valid & ready
- o_rsp_data  out  32  read data; 0 for write, error or illegal
- o_rsp_addr  out  5  register index of this beat
- o_rsp_last  out  1  final beat of the command
- o_rsp_err  out  1  halt timeout or illegal op
- o_halt_req  out  1  core halt request
- i_halted  in  1  core halted acknowledge
- o_rf_sel  out  1  debug owns RF ports (mux select)
- o_rf_raddr  out  5  RF read address
- i_rf_rdata  in  32  RF read data (combinational from `o_rf_raddr`)
- o_rf_wen, o_rf_waddr[5], o_rf_wdata[32]  out  RF write port

## Operation
- States: IDLE, WAIT_HALT, ACCESS, RESP.
- IDLE:
  - `o_cmd_ready`=1. All other outputs are 0.
  - On accept, latch op, addr and wdata.
  - Op 11: go to RESP with err=1, last=1, data=0, addr=latched addr. No halt is requested.
  - Otherwise: go to WAIT_HALT and clear the timeout counter.
- WAIT_HALT:
  - `o_halt_req`=1.
  - `i_halted`=1: go to ACCESS.
  - Otherwise increment the counter. When the counter reaches HALT_TIMEOUT, go to RESP with err=1, data=0, last=1. No RF access occurs.
- ACCESS (exactly one cycle per beat):
  - `o_rf_sel`=1 and `o_halt_req`=1.
  - Read or dump beat: `o_rf_raddr`=current index. `i_rf_rdata` is captured into `o_rsp_data` at the cycle end.
  - Write: `o_rf_wen`=1, `o_rf_waddr`=addr, `o_rf_wdata`=wdata. The response data is 0.
  - A write to x0 is still issued. The RF discards it.
  - Next state is RESP.
- RESP:
  - `o_rsp_valid`=1. All `o_rsp_*` fields are held stable until handshake.
  - `o_halt_req` and `o_rf_sel` stay as in ACCESS, except on the error paths, where `o_rf_sel` stays 0.
  - On handshake, a dump with index < 31 increments the index and returns to ACCESS.
  - On any other handshake, go to IDLE.
- Dump:
  - Index runs 0..31.
  - `o_rsp_last`=1 only on index 31. The 5-bit index is never wrapped past 31.
- When `o_rf_sel`=0, all `o_rf_*` outputs are 0.
- `o_halt_req` deasserts the cycle after the final handshake. The block does not wait for `i_halted` to fall.
- A new command is not accepted before returning to IDLE.

## Timing
- Reset:
  - State goes to IDLE and the counter and latches clear.
  - The cycle after the reset edge, `o_cmd_ready`=1 and every other output is 0.
- Reset mid-operation aborts immediately:
  - No further `o_rf_wen` is issued and no response is produced.
  - `o_halt_req` and `o_rf_sel` drop the cycle after the reset edge.
- Accept at cycle T gives `o_halt_req`=1 from T+1.
- If `i_halted` is first high at cycle H (H≥T+1):
  - ACCESS occurs at H+1.
  - `o_rsp_valid` is asserted from H+2.
- Write lands in the RF at the clock edge ending cycle H+1.
- Dump throughput is at most one beat per 2 cycles (ACCESS + RESP). Back-pressure only stretches RESP.
- Timeout: with `i_halted` held low, `o_rsp_valid`=1 at T+1+HALT_TIMEOUT.
- Illegal op: `o_rsp_valid`=1 at T+1.
- `o_cmd_ready` is a function of the registered state only, with no combinational path from `i_cmd_valid`.

## Test plan
- **Write then read:** set `i_halted`=1 two cycles after `o_halt_req` rises. Write x5=0xDEADBEEF, then read x5.
  - Write: `o_rf_wen` is a single-cycle pulse with waddr=5, and the response has err=0, last=1, data=0.
  - Read: the response data is 0xDEADBEEF, with halt latency exactly as specified.
- **x0 protection:** write x0=0x12345678, then read x0. The write pulse is issued and the read response data is 0x00000000.
- **Dump with back-pressure:** preload the RF with xi = i×0x01010101 and drive `i_rsp_ready` with a random 50% pattern.
  - Exactly 32 beats, with addr 0..31 and matching data.
  - last=1 only on addr 31.
  - Fields stay stable while stalled.
  - `o_halt_req` is 0 the cycle after the final handshake.
- **Halt timeout:** hold `i_halted`=0 and issue a read.
  - Response err=1, data=0 at T+17.
  - `o_rf_sel` is never 1.
  - `o_halt_req` drops after the handshake.
- **Illegal op:** issue op=11 with addr=7. The response at T+1 has err=1, addr=7, last=1, and `o_halt_req` is never asserted.
- **Reset mid-dump:** assert `i_rst` during beat 10.
  - The next cycle has `o_rsp_valid`=0, `o_halt_req`=0, `o_rf_sel`=0 and `o_cmd_ready`=1.
  - A following read of x3 returns correct data.

Source files
------------

// File: rtl/rf_dbg_master.sv
// Debug access initiator for the register file.
// Takes read/write/dump commands, halts the core, then drives the RF ports
// one beat at a time and returns each beat on a valid/ready response channel.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | ready for a command; all other outputs low
// WAIT_HALT | halt requested, waiting for i_halted (bounded by HALT_TIMEOUT)
// ACCESS    | one cycle owning the RF ports for the current beat
// RESP      | response beat presented until consumed
module rf_dbg_master #(
  parameter int HALT_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [4:0]  i_cmd_addr,
  input  logic [31:0] i_cmd_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic [4:0]  o_rsp_addr,
  output logic        o_rsp_last,
  output logic        o_rsp_err,
  output logic        o_halt_req,
  input  logic        i_halted,
  output logic        o_rf_sel,
  output logic [4:0]  o_rf_raddr,
  input  logic [31:0] i_rf_rdata,
  output logic        o_rf_wen,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata
);

  typedef enum logic [1:0] {IDLE, WAIT_HALT, ACCESS, RESP} state_t;

  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_DUMP    = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;
  localparam int         CW         = $clog2(HALT_TIMEOUT + 1);

  state_t        state;
  logic [1:0]    op;
  logic [4:0]    idx;
  logic [31:0]   wdata;
  logic [CW-1:0] cnt;

  // Command sequencing with every output registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      op          <= 2'b00;
      idx         <= 5'd0;
      wdata       <= 32'd0;
      cnt         <= '0;
      o_cmd_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= 32'd0;
      o_rsp_addr  <= 5'd0;
      o_rsp_last  <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_halt_req  <= 1'b0;
      o_rf_sel    <= 1'b0;
      o_rf_raddr  <= 5'd0;
      o_rf_wen    <= 1'b0;
      o_rf_waddr  <= 5'd0;
      o_rf_wdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_valid && o_cmd_ready) begin
            op          <= i_cmd_op;
            wdata       <= i_cmd_wdata;
            idx         <= (i_cmd_op == OP_DUMP) ? 5'd0 : i_cmd_addr;
            o_cmd_ready <= 1'b0;
            if (i_cmd_op == OP_ILLEGAL) begin
              // Rejected without touching the core or the RF.
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_last  <= 1'b1;
              o_rsp_data  <= 32'd0;
              o_rsp_addr  <= i_cmd_addr;
            end else begin
              state      <= WAIT_HALT;
              cnt        <= '0;
              o_halt_req <= 1'b1;
            end
          end
        end
        WAIT_HALT: begin
          if (i_halted) begin
            state    <= ACCESS;
            o_rf_sel <= 1'b1;
            if (op == OP_WRITE) begin
              o_rf_wen   <= 1'b1;
              o_rf_waddr <= idx;
              o_rf_wdata <= wdata;
            end else begin
              o_rf_raddr <= idx;
            end
          end else if (cnt == CW'(HALT_TIMEOUT - 1)) begin
            // Core never acknowledged: report an error beat, RF untouched.
            state       <= RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rsp_last  <= 1'b1;
            o_rsp_data  <= 32'd0;
            o_rsp_addr  <= idx;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ACCESS: begin
          state       <= RESP;
          o_rf_wen    <= 1'b0;
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= 1'b0;
          o_rsp_addr  <= idx;
          o_rsp_last  <= (op != OP_DUMP) || (idx == 5'd31);
          o_rsp_data  <= (op == OP_WRITE) ? 32'd0 : i_rf_rdata;
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= 32'd0;
            o_rsp_addr  <= 5'd0;
            o_rsp_last  <= 1'b0;
            o_rsp_err   <= 1'b0;
            if (op == OP_DUMP && o_rf_sel && idx != 5'd31) begin
              state      <= ACCESS;
              idx        <= idx + 5'd1;
              o_rf_raddr <= idx + 5'd1;
            end else begin
              state       <= IDLE;
              o_cmd_ready <= 1'b1;
              o_halt_req  <= 1'b0;
              o_rf_sel    <= 1'b0;
              o_rf_raddr  <= 5'd0;
              o_rf_waddr  <= 5'd0;
              o_rf_wdata  <= 32'd0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dbg_master.sv
// Bench for rf_dbg_master: table vectors, a dump with back-pressure, a reset
// mid-dump and randomized commands against a simple register-array model.
module tb_rf_dbg_master;
  localparam int HT = 16;

  logic        i_clk = 0;
  logic        i_rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd_op;
  logic [4:0]  i_cmd_addr;
  logic [31:0] i_cmd_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic [4:0]  o_rsp_addr;
  logic        o_rsp_last;
  logic        o_rsp_err;
  logic        o_halt_req;
  logic        i_halted;
  logic        o_rf_sel;
  logic [4:0]  o_rf_raddr;
  logic [31:0] i_rf_rdata;
  logic        o_rf_wen;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;

  rf_dbg_master #(.HALT_TIMEOUT(HT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_addr(o_rsp_addr),
    .o_rsp_last(o_rsp_last), .o_rsp_err(o_rsp_err),
    .o_halt_req(o_halt_req), .i_halted(i_halted),
    .o_rf_sel(o_rf_sel), .o_rf_raddr(o_rf_raddr), .i_rf_rdata(i_rf_rdata),
    .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata)
  );

  always #5 i_clk = ~i_clk;

  // Register file stand-in: async read, sync write, x0 hardwired to zero.
  logic [31:0] rf_mem [32];
  logic        preload;
  assign i_rf_rdata = (o_rf_raddr == 5'd0) ? 32'd0 : rf_mem[o_rf_raddr];

  always @(posedge i_clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= i * 32'h01010101;
    end else if (o_rf_wen && o_rf_waddr != 5'd0) begin
      rf_mem[o_rf_waddr] <= o_rf_wdata;
    end
  end

  // Expected architectural contents of the RF.
  logic [31:0] mem [32];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_preload();
    preload = 1;
    @(negedge i_clk);
    preload = 0;
    for (int i = 0; i < 32; i++) mem[i] = (i == 0) ? 32'd0 : i * 32'h01010101;
  endtask

  // Issue one command and follow it to completion. hdelay = cycles after the
  // halt request rises before i_halted goes high; rdy_pct = chance of ready.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] addr,
                         input logic [31:0] wd, input int hdelay, input int rdy_pct,
                         output logic [31:0] d0, output logic e0);
    bit illegal, tmo, holding, done;
    int nbeats, beats, k, first_sel_k, first_valid_k;
    int wen_cnt, halt_seen, sel_seen, zero_viol, stall_viol, ready_viol, bad_wr;
    logic [31:0] ed, hd;
    logic [4:0]  ea, ha;
    logic        el, hl, he;
    illegal = (op == 2'b11);
    tmo     = !illegal && (hdelay >= HT);
    nbeats  = (op == 2'b10 && !tmo) ? 32 : 1;
    beats = 0; holding = 0; done = 0; first_sel_k = -1; first_valid_k = -1;
    wen_cnt = 0; halt_seen = 0; sel_seen = 0; zero_viol = 0; stall_viol = 0;
    ready_viol = 0; bad_wr = 0; d0 = 32'hx; e0 = 1'bx;
    hd = 0; ha = 0; hl = 0; he = 0;
    chk("cmd_ready_before", {31'd0, o_cmd_ready}, 32'd1);
    i_cmd_valid = 1; i_cmd_op = op; i_cmd_addr = addr; i_cmd_wdata = wd;
    @(negedge i_clk);
    i_cmd_valid = 0;
    k = 1;
    while (!done && k < 600) begin
      i_halted = (k >= 1 + hdelay);
      if (o_rf_sel) begin
        sel_seen++;
        if (first_sel_k < 0) first_sel_k = k;
      end
      if (!o_rf_sel && (o_rf_wen || o_rf_raddr != 0 || o_rf_waddr != 0 || o_rf_wdata != 0))
        zero_viol++;
      if (o_halt_req) halt_seen++;
      if (o_cmd_ready) ready_viol++;
      if (o_rf_wen) begin
        wen_cnt++;
        if (o_rf_waddr != addr || o_rf_wdata != wd) bad_wr++;
      end
      if (o_rsp_valid) begin
        if (!holding) begin
          if (beats == 0) first_valid_k = k;
          if (illegal || tmo) begin
            ed = 0; ea = addr; el = 1;
          end else if (op == 2'b10) begin
            ed = mem[beats]; ea = 5'(beats); el = (beats == 31);
          end else begin
            ed = (op == 2'b01) ? 32'd0 : mem[addr]; ea = addr; el = 1;
          end
          chk("rsp_data", o_rsp_data, ed);
          chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, illegal || tmo});
          chk("rsp_last", {31'd0, o_rsp_last}, {31'd0, el});
          if (!tmo) chk("rsp_addr", {27'd0, o_rsp_addr}, {27'd0, ea});
          if (beats == 0) begin d0 = o_rsp_data; e0 = o_rsp_err; end
          hd = o_rsp_data; ha = o_rsp_addr; hl = o_rsp_last; he = o_rsp_err;
          holding = 1;
        end else if (o_rsp_data != hd || o_rsp_addr != ha || o_rsp_last != hl || o_rsp_err != he) begin
          stall_viol++;
        end
        i_rsp_ready = ($urandom_range(99) < rdy_pct);
        if (i_rsp_ready) begin
          beats++;
          holding = 0;
          if (beats == nbeats) done = 1;
        end
      end else begin
        i_rsp_ready = 0;
      end
      @(negedge i_clk);
      k++;
    end
    i_rsp_ready = 0;
    i_halted = 0;
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL cmd_timeout: got %0d beats, expected %0d", beats, nbeats);
    end
    chk("halt_after_last", {31'd0, o_halt_req}, 32'd0);
    chk("ready_after_last", {31'd0, o_cmd_ready}, 32'd1);
    chk("sel_after_last", {31'd0, o_rf_sel}, 32'd0);
    chk("beats", beats, nbeats);
    chk("rsp_latency", first_valid_k, illegal ? 1 : (tmo ? 1 + HT : hdelay + 3));
    chk("access_cycle", first_sel_k, (illegal || tmo) ? -1 : hdelay + 2);
    chk("wen_pulses", wen_cnt, (op == 2'b01 && !tmo) ? 1 : 0);
    chk("wen_fields", bad_wr, 0);
    chk("rf_zero_when_unsel", zero_viol, 0);
    chk("rsp_stable", stall_viol, 0);
    chk("ready_while_busy", ready_viol, 0);
    if (illegal) chk("halt_on_illegal", halt_seen, 0);
    if (op == 2'b01 && !tmo && addr != 0) mem[addr] = wd;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  addr;
    logic [31:0] wd;
    int          hd;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [31:0] d;
    logic        e;
    int          n;
    tbl[0] = '{2'b01, 5'd5,  32'hDEADBEEF, 2,  32'h0,        1'b0};
    tbl[1] = '{2'b00, 5'd5,  32'h0,        2,  32'hDEADBEEF, 1'b0};
    tbl[2] = '{2'b01, 5'd0,  32'h12345678, 2,  32'h0,        1'b0};
    tbl[3] = '{2'b00, 5'd0,  32'h0,        2,  32'h0,        1'b0};
    tbl[4] = '{2'b00, 5'd5,  32'h0,        16, 32'h0,        1'b1};
    tbl[5] = '{2'b00, 5'd5,  32'h0,        15, 32'hDEADBEEF, 1'b0};
    tbl[6] = '{2'b11, 5'd7,  32'h0,        0,  32'h0,        1'b1};
    tbl[7] = '{2'b01, 5'd31, 32'hA5A50F0F, 0,  32'h0,        1'b0};
    tbl[8] = '{2'b00, 5'd31, 32'h0,        0,  32'hA5A50F0F, 1'b0};
    tbl[9] = '{2'b00, 5'd31, 32'h0,        40, 32'h0,        1'b1};

    i_rst = 1; i_cmd_valid = 0; i_cmd_op = 0; i_cmd_addr = 0; i_cmd_wdata = 0;
    i_rsp_ready = 0; i_halted = 0; preload = 0;
    @(negedge i_clk);
    do_preload();
    chk("reset_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("reset_halt_req", {31'd0, o_halt_req}, 32'd0);
    chk("reset_rf_sel", {31'd0, o_rf_sel}, 32'd0);
    chk("reset_rf_wen", {31'd0, o_rf_wen}, 32'd0);
    chk("reset_rsp_data", o_rsp_data, 32'd0);
    i_rst = 0;
    @(negedge i_clk);

    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].hd, 100, d, e);
      chk($sformatf("tbl%0d_data", i), d, tbl[i].ed);
      chk($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].ee});
      @(negedge i_clk);
    end

    do_preload();
    run_cmd(2'b10, 5'd9, 32'h0, 1, 50, d, e);
    @(negedge i_clk);

    // Reset while beat 10 of a dump is being presented.
    i_cmd_valid = 1; i_cmd_op = 2'b10; i_cmd_addr = 0;
    @(negedge i_clk);
    i_cmd_valid = 0; i_halted = 1; i_rsp_ready = 1;
    n = 0;
    while (!(o_rsp_valid && o_rsp_addr == 5'd10) && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    chk("reach_beat10", {31'd0, n < 200}, 32'd1);
    i_rst = 1; i_rsp_ready = 0;
    @(negedge i_clk);
    chk("rst_mid_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_mid_halt_req", {31'd0, o_halt_req}, 32'd0);
    chk("rst_mid_rf_sel", {31'd0, o_rf_sel}, 32'd0);
    chk("rst_mid_rf_wen", {31'd0, o_rf_wen}, 32'd0);
    chk("rst_mid_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
    i_rst = 0; i_halted = 0;
    @(negedge i_clk);
    run_cmd(2'b00, 5'd3, 32'h0, 1, 100, d, e);
    chk("post_rst_read_x3", d, 32'h03030303);
    @(negedge i_clk);

    for (int i = 0; i < 30; i++) begin
      int          r;
      logic [1:0]  op;
      r  = $urandom_range(9);
      op = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b11 : 2'b10;
      run_cmd(op, 5'($urandom_range(31)), $urandom, $urandom_range(18), 60, d, e);
      if ($urandom_range(1) == 1) @(negedge i_clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
